// File: rtl/mul_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, one-hot Booth digit
// selects, and W/N derivation from the operand width.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        SEL_ZERO = 4'b0000,
        SEL_NEG1 = 4'b0001,
        SEL_POS1 = 4'b0010,
        SEL_NEG2 = 4'b0100,
        SEL_POS2 = 4'b1000
    } booth_sel_e;

    // Two extra bits let the unsigned 64-bit case be treated as signed 66-bit.
    function automatic int booth_w(input int xlen);
        return xlen + 2;
    endfunction

    function automatic int booth_n(input int xlen);
        return (xlen + 2) / 2;
    endfunction

    function automatic booth_sel_e booth_decode(input logic [2:0] digit);
        booth_sel_e sel;
        sel = SEL_ZERO;
        case (digit)
            3'b001, 3'b010: sel = SEL_POS1;
            3'b011:         sel = SEL_POS2;
            3'b100:         sel = SEL_NEG2;
            3'b101, 3'b110: sel = SEL_NEG1;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial product: combinational, zero latency, no handshake.
// Negative digits return the one's complement; the +1 goes out on neg_cin_o.
module booth_r4_pp
    import mul_pkg::*;
#(
    parameter int W2 = 132
) (
    input  logic [2:0]    digit_i,
    input  logic [W2-1:0] md_i,
    output logic [W2-1:0] pp_o,
    output logic          neg_cin_o
);

    booth_sel_e sel;

    assign sel = booth_decode(digit_i);

    always_comb begin
        pp_o      = '0;
        neg_cin_o = 1'b0;
        case (sel)
            SEL_POS1: pp_o = md_i;
            SEL_POS2: pp_o = {md_i[W2-2:0], 1'b0};
            SEL_NEG1: begin
                pp_o      = ~md_i;
                neg_cin_o = 1'b1;
            end
            SEL_NEG2: begin
                pp_o      = ~{md_i[W2-2:0], 1'b0};
                neg_cin_o = 1'b1;
            end
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_r4.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU/MULW); k+2 edges from accept
// to out_valid with early out; result held in DONE until out_ready, flush kills anything.
module booth_mul_r4
    import mul_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int WORD_EN   = 1,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic            sel_hi,
    input  logic            word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int W  = booth_w(XLEN);
    localparam int N  = booth_n(XLEN);
    localparam int CW = $clog2(N + 1);
    localparam int WB = (XLEN < 32) ? XLEN - 1 : 31;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = (i <= WB) ? v[i] : v[WB];
        return r;
    endfunction

    state_e          state_q;
    logic [W:0]      mr_q;
    logic [2*W-1:0]  md_q;
    logic [2*W-1:0]  acc_q;
    logic [CW-1:0]   cnt_q;
    logic            sel_hi_q;
    logic            word_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;

    logic            word_m;
    logic            a_sx;
    logic            b_sx;
    logic [XLEN-1:0] a_src;
    logic [XLEN-1:0] b_src;
    logic [W-1:0]    a_ext;
    logic [W-1:0]    b_ext;
    logic [2*W-1:0]  pp;
    logic            neg_cin;
    logic            terminate;
    logic [2*W-1:0]  acc_d;
    logic [XLEN-1:0] result_d;

    assign word_m = word && (WORD_EN != 0);
    assign a_sx   = a_signed || word_m;
    assign b_sx   = b_signed || word_m;
    assign a_src  = word_m ? sext_w(op_a) : op_a;
    assign b_src  = word_m ? sext_w(op_b) : op_b;
    assign a_ext  = {{2{a_sx & a_src[XLEN-1]}}, a_src};
    assign b_ext  = {{2{b_sx & b_src[XLEN-1]}}, b_src};

    booth_r4_pp #(.W2(2*W)) u_pp (
        .digit_i   (mr_q[2:0]),
        .md_i      (md_q),
        .pp_o      (pp),
        .neg_cin_o (neg_cin)
    );

    // A uniform multiplier register means every remaining Booth digit is zero.
    assign terminate = (cnt_q == CW'(N)) ||
                       ((EARLY_OUT != 0) && ((&mr_q) || (~|mr_q)));
    assign acc_d     = acc_q + pp + {{(2*W-1){1'b0}}, neg_cin};
    assign result_d  = word_q ? sext_w(acc_q[XLEN-1:0])
                     : (sel_hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mr_q        <= '0;
            md_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sel_hi_q    <= 1'b0;
            word_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mr_q     <= {b_ext, 1'b0};
                        md_q     <= {{W{a_ext[W-1]}}, a_ext};
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        sel_hi_q <= sel_hi;
                        word_q   <= word_m;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (terminate) begin
                        result_q    <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        md_q  <= {md_q[2*W-3:0], 2'b00};
                        mr_q  <= {{2{mr_q[W]}}, mr_q[W:2]};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
